// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard and stall sequencer for the 16-bit datapath. Detects
// load-use hazards, data-memory wait states and taken branches, and drives
// the next-address mux select, the IF/ID write-enable, the ID/EX bubble and
// the IF/ID flush. A saturating counter records the cycles spent holding PC.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2   ID instruction actually reads that source
//   ex_mem_read, ex_rd         EX instruction is a load / its destination
//   branch_taken               branch resolved taken in EX this cycle
//   mem_busy                   data memory not ready, freeze the pipeline
//   HazMuxCon                  1 = hold PC (+0), 0 = PC+2
//   if_id_write                IF/ID load enable
//   id_ex_bubble               insert NOP into ID/EX
//   if_id_flush                squash IF/ID (wrong path)
//   state                      RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3
//   stall_count                saturating count of cycles with HazMuxCon=1
//
// The control outputs are combinational from the current state and inputs
// (zero-cycle hazard response), which is why they carry no register stage.

module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned REG_BITS     = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                ex_mem_read,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic                HazMuxCon,
    output logic                if_id_write,
    output logic                id_ex_bubble,
    output logic                if_id_flush,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    stall_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_e;

    localparam int unsigned      FCW        = 3;
    localparam logic [FCW-1:0]   FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e           state_q;
    state_e           state_d;
    logic [FCW-1:0]   flush_cnt;
    logic [FCW-1:0]   flush_cnt_d;
    logic             load_use_c;

    // Load-use hazard; register 0 is hard-wired and never a real dependency.
    assign load_use_c = ex_mem_read && (ex_rd != '0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt;
        HazMuxCon    = 1'b0;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;

        case (state_q)
            // RUN, LOAD_STALL and a MEM_WAIT whose memory just became ready
            // share one priority chain; only LOAD_STALL masks the hazard.
            ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    HazMuxCon    = 1'b1;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b1;
                    if (FLUSH_INIT != '0) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (load_use_c && (state_q != ST_LOAD_STALL)) begin
                    HazMuxCon    = 1'b1;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end

            // Wrong-path squash; a busy memory freezes the countdown.
            ST_FLUSH: begin
                if (mem_busy) begin
                    HazMuxCon    = 1'b1;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else begin
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b1;
                    flush_cnt_d  = flush_cnt - FCW'(1);
                    if (flush_cnt <= FCW'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = ST_RUN;
                    end
                end
            end

            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase

        // Hold the pipeline while reset is asserted.
        if (!rst_n) begin
            HazMuxCon    = 1'b1;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
        end
    end

    // State, flush countdown and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state_q   <= state_d;
            flush_cnt <= flush_cnt_d;
            if (HazMuxCon && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (default parameters).
// Each row of stimulus pushes its expected observation to a scoreboard; the
// observation is popped and compared at the following falling edge.

module tb_hazard_controller;

    typedef struct packed {
        logic       mb;
        logic       bt;
        logic       ld;
        logic [3:0] exrd;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2;
    } stim_t;

    typedef struct packed {
        logic       hmc;
        logic       wr;
        logic       bub;
        logic       fl;
        logic [1:0] st;
        logic [7:0] cnt;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;
    logic       HazMuxCon, if_id_write, id_ex_bubble, if_id_flush;
    logic [1:0] state;
    logic [7:0] stall_count;

    obs_t        sb[$];
    int          total   = 0;
    int          bad     = 0;
    int unsigned exp_cnt = 0;

    hazard_controller #(
        .FLUSH_CYCLES(2),
        .REG_BITS    (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .HazMuxCon   (HazMuxCon),
        .if_id_write (if_id_write),
        .id_ex_bubble(id_ex_bubble),
        .if_id_flush (if_id_flush),
        .state       (state),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk_s(logic mb, logic bt, logic ld, logic [3:0] exrd,
                                   logic [3:0] rs1, logic u1, logic [3:0] rs2, logic u2);
        stim_t s;
        s.mb = mb; s.bt = bt; s.ld = ld; s.exrd = exrd;
        s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        return s;
    endfunction

    function automatic obs_t mk_x(logic h, logic w, logic b, logic f, logic [1:0] st);
        obs_t x;
        x.hmc = h; x.wr = w; x.bub = b; x.fl = f; x.st = st; x.cnt = 8'd0;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.hmc = HazMuxCon; o.wr = if_id_write; o.bub = id_ex_bubble;
        o.fl = if_id_flush; o.st = state; o.cnt = stall_count;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        mem_busy     = s.mb;
        branch_taken = s.bt;
        ex_mem_read  = s.ld;
        ex_rd        = s.exrd;
        id_rs1       = s.rs1;
        id_uses_rs1  = s.u1;
        id_rs2       = s.rs2;
        id_uses_rs2  = s.u2;
    endtask

    // Expected: hold-PC, write, bubble, flush, state; count tracked by exp_cnt.
    localparam obs_t X_MEM  = 14'b1010_00_00000000;

    task automatic test_reset();
        stim_t s[$];
        obs_t  x[$];
        obs_t  e, g;
        for (int i = 0; i < 4; i++) begin
            s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0));
            x.push_back(mk_x(1, 0, 1, 0, (i == 0) ? 2'd0 : 2'd2));
        end
        s.push_back(mk_s(0, 0, 1, 3, 3, 1, 0, 0));
        x.push_back(mk_x(1, 0, 1, 0, 2'd2));
        for (int i = 0; i < s.size(); i++) begin
            obs_t ee, gg;
            apply(s[i]);
            ee = x[i]; ee.cnt = 8'(exp_cnt);
            sb.push_back(ee);
            @(negedge clk);
            ee = sb.pop_front(); gg = sample();
            total++;
            if (gg !== ee) begin
                bad++;
                $display("FAIL reset_setup[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, gg[13:10], gg.st, gg.cnt, ee[13:10], ee.st, ee.cnt);
            end
            if (ee.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
        // Now in LOAD_STALL with five stall cycles counted.
        apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0));
        e = mk_x(0, 1, 0, 0, 2'd1); e.cnt = 8'(exp_cnt);
        sb.push_back(e);
        #1;
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset_pre: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                     g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
        end
        rst_n = 1'b0;
        exp_cnt = 0;
        e = X_MEM;
        sb.push_back(e);
        #1;
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset_async: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                     g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
        end
        #1 rst_n = 1'b1;
        e = mk_x(0, 1, 0, 0, 2'd0); e.cnt = 8'(exp_cnt);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset_release: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                     g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t s[$];
        obs_t  x[$];
        s.push_back(mk_s(0, 0, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 0, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd1));
        s.push_back(mk_s(0, 0, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd1));
        s.push_back(mk_s(0, 0, 1, 0, 0, 1, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        s.push_back(mk_s(0, 0, 1, 0, 0, 1, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        s.push_back(mk_s(0, 0, 1, 5, 0, 0, 5, 1)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd1));
        s.push_back(mk_s(0, 0, 1, 5, 5, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        s.push_back(mk_s(0, 0, 0, 3, 3, 1, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < s.size(); i++) begin
            obs_t e, g;
            apply(s[i]);
            e = x[i]; e.cnt = 8'(exp_cnt);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL load_use[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
            end
            if (e.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_flush();
        stim_t s[$];
        obs_t  x[$];
        s.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd0));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd3));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < s.size(); i++) begin
            obs_t e, g;
            apply(s[i]);
            e = x[i]; e.cnt = 8'(exp_cnt);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL branch_flush[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
            end
            if (e.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        obs_t  x[$];
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd2));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd2));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd2));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < s.size(); i++) begin
            obs_t e, g;
            apply(s[i]);
            e = x[i]; e.cnt = 8'(exp_cnt);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL mem_wait[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
            end
            if (e.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        obs_t  x[$];
        // busy + branch + hazard, then the MEM_WAIT exit cycle
        s.push_back(mk_s(1, 1, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd2));
        // branch + hazard, busy freezes the flush for two cycles
        s.push_back(mk_s(0, 1, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd3));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd3));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd3));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        // branch taken while in LOAD_STALL
        s.push_back(mk_s(0, 0, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 1, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd1));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd3));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        // branch and hazard ignored inside FLUSH
        s.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd0));
        s.push_back(mk_s(0, 1, 1, 3, 3, 1, 0, 0)); x.push_back(mk_x(0, 1, 1, 1, 2'd3));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        // hazard on the cycle memory becomes ready
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(1, 0, 1, 0, 2'd0));
        s.push_back(mk_s(0, 0, 1, 7, 0, 0, 7, 1)); x.push_back(mk_x(1, 0, 1, 0, 2'd2));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd1));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < s.size(); i++) begin
            obs_t e, g;
            apply(s[i]);
            e = x[i]; e.cnt = 8'(exp_cnt);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL priority[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
            end
            if (e.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        stim_t s[$];
        obs_t  x[$];
        for (int i = 0; i < 300; i++) begin
            s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0));
            x.push_back(mk_x(1, 0, 1, 0, (i == 0) ? 2'd0 : 2'd2));
        end
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd2));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(mk_x(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < s.size(); i++) begin
            obs_t e, g;
            apply(s[i]);
            e = x[i]; e.cnt = 8'(exp_cnt);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL saturation[%0d]: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                         i, g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
            end
            if (e.hmc && exp_cnt < 255) exp_cnt++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_count !== 8'd255) begin
            bad++;
            $display("FAIL saturation_final: got cnt=%0d want cnt=255", stall_count);
        end
    endtask

    initial begin
        obs_t e, g;
        rst_n = 1'b0;
        apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = X_MEM;
        sb.push_back(e);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL power_on_reset: got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                     g[13:10], g.st, g.cnt, e[13:10], e.st, e.cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0;

        test_reset();
        test_load_use();
        test_branch_flush();
        test_mem_wait();
        test_priority();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 16-bit datapath. It detects load-use hazards, memory wait states and taken branches. It drives `HazMuxCon` into the next-address mux (0 = PC+2, 1 = hold PC) together with the IF/ID write-enable, ID/EX bubble and IF/ID flush controls. It also keeps a saturating stall-cycle counter for performance visibility.

## Interface
- `FLUSH_CYCLES`, default 2: total cycles `if_id_flush` is asserted per taken branch; legal range 1..7.
- `REG_BITS`, default 4: register-specifier width.
- `CNT_W`, default 8: stall counter width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `id_rs1`, `id_rs2` in REG_BITS: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads that source.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rd` in REG_BITS: destination register of the EX instruction.
- `branch_taken` in 1: branch resolved taken in EX this cycle.
- `mem_busy` in 1: data memory is not ready; pipeline must freeze.
- `HazMuxCon` out 1: 1 = next-address mux selects +0 (hold PC); 0 = +2.
- `if_id_write` out 1: IF/ID register load enable.
- `id_ex_bubble` out 1: insert NOP into ID/EX.
- `if_id_flush` out 1: clear IF/ID (wrong-path squash).
- `state` out 2: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.
- `stall_count` out CNT_W: count of cycles with `HazMuxCon`=1.

## Operation
- **State register.** Registered 2-bit `state` plus a 3-bit flush down-counter `flush_cnt`.
- **Output decode.** Outputs are combinational from the current state and inputs.
- **Default ("normal") outputs:** `HazMuxCon`=0, `if_id_write`=1, `id_ex_bubble`=0, `if_id_flush`=0.
- **Load-use hazard:** `ex_mem_read` && `ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)). Register 0 never causes a hazard.
- **Evaluation order in RUN, highest priority first:**
  1. **`mem_busy`**
     - Outputs: `HazMuxCon`=1, `if_id_write`=0, `id_ex_bubble`=1, `if_id_flush`=0.
     - Next state: MEM_WAIT.
  2. **`branch_taken`**
     - Outputs: `HazMuxCon`=0, `if_id_write`=1, `id_ex_bubble`=1, `if_id_flush`=1.
     - Next state: FLUSH with `flush_cnt`=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  3. **Load-use hazard**
     - Outputs: `HazMuxCon`=1, `if_id_write`=0, `id_ex_bubble`=1.
     - Next state: LOAD_STALL.
  4. **Otherwise:** normal outputs; stay in RUN.
- **LOAD_STALL:** hazard detection is masked. `mem_busy` and `branch_taken` are evaluated exactly as in RUN; otherwise normal outputs. Always leaves in one cycle, to MEM_WAIT, FLUSH or RUN per those rules.
- **MEM_WAIT:** while `mem_busy`=1, same outputs as the RUN `mem_busy` case; hold state. In the cycle `mem_busy`=0, behave exactly as RUN (full priority evaluation, same outputs, same next state).
- **FLUSH:**
  - `mem_busy`=1: freeze. Outputs are the `mem_busy` outputs with `if_id_flush`=0; state and `flush_cnt` are held.
  - Otherwise: `if_id_flush`=1, `id_ex_bubble`=1, `HazMuxCon`=0, `if_id_write`=1; decrement `flush_cnt`.
  - Exit to RUN when `flush_cnt` reaches 0 after the decrement.
  - `branch_taken` and load-use hazards are ignored in FLUSH (wrong-path or bubbled instructions).
- **Dropped branch under `mem_busy`:** a `branch_taken` that loses to `mem_busy` is not remembered. The frozen EX stage re-presents it when `mem_busy` drops.
- **`stall_count`:** increments by 1 on each rising edge where `rst_n`=1 and `HazMuxCon`=1. Saturates at 2^CNT_W-1 and never wraps.

## Timing
- **While `rst_n`=0, immediately (asynchronous):**
  - `state`=RUN, `flush_cnt`=0, `stall_count`=0.
  - Outputs forced to `HazMuxCon`=1, `if_id_write`=0, `id_ex_bubble`=1, `if_id_flush`=0.
- **Reset mid-operation:** reset asserted during a stall or flush aborts it; no residual stall after release.
- **After reset release:** the first edge evaluates from RUN.
- **Latency:** zero-cycle combinational response to hazard, `mem_busy` and `branch_taken` inputs. State changes take effect the cycle after the edge.
- **Load-use stall length:** exactly 1 cycle per hazard.
- **Flush length:** FLUSH_CYCLES non-frozen cycles per taken branch.
- **Memory stall length:** equals the number of `mem_busy` cycles.

## Test plan
- **Reset behaviour:** drop `rst_n` while in LOAD_STALL with `stall_count`=5, inputs idle.
  - During reset: `HazMuxCon`=1, `id_ex_bubble`=1, `state`=0 and `stall_count`=0 immediately, without waiting for `clk`.
  - After release: `HazMuxCon`=0 and `if_id_write`=1.
- **Load-use stall:** `ex_mem_read`=1, `ex_rd`=3, `id_rs1`=3, `id_uses_rs1`=1, held 2 cycles.
  - Cycle N: `HazMuxCon`=1, `id_ex_bubble`=1.
  - Cycle N+1: `state`=1 and `HazMuxCon`=0.
  - `stall_count`=1.
  - Repeat with `ex_rd`=0: no stall.
- **Branch flush:** `branch_taken` pulse at cycle N with FLUSH_CYCLES=2. `if_id_flush`=1 at N and N+1, `state`=3 at N+1, RUN with `if_id_flush`=0 at N+2. `HazMuxCon`=0 throughout.
- **Memory wait:** `mem_busy`=1 for 3 cycles.
  - `HazMuxCon`=1 for 3 cycles; `state`=2 from the second cycle.
  - `stall_count` increases by 3; normal outputs in the 4th cycle.
- **Priority:**
  - `mem_busy`+`branch_taken`+hazard in the same cycle: `mem_busy` outputs, `if_id_flush`=0.
  - `branch_taken`+hazard: flush, `HazMuxCon`=0, `state`→3.
  - `mem_busy`=1 for 2 cycles during FLUSH: `flush_cnt` is held and the flush resumes afterwards.
- **Saturation:** `mem_busy`=1 for 300 cycles with CNT_W=8: `stall_count`=255 and stays at 255.
